// File: rtl/id_inst_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_inst_queue_pkg
// Brief    : Shared types and constants for the IF->ID instruction queue.
// Revision : 1.0
// ============================================================================
package id_inst_queue_pkg;

    localparam int INSTQ_DEPTH  = 4;
    localparam int INSTQ_PC_W   = 32;
    localparam int INSTQ_INST_W = 32;

    // Pipeline stall encodings as driven by the control unit
    localparam logic c_STOP   = 1'b1;
    localparam logic c_NOSTOP = 1'b0;

    typedef enum logic [2:0] {
        FL_NONE      = 3'd0,
        FL_DROP_ALL  = 3'd1,
        FL_KEEP_HEAD = 3'd2,
        FL_KEEP_RSP  = 3'd3,
        FL_ARM_KEEP  = 3'd4
    } flush_act_e;

    function automatic int entry_w(input int pc_w, input int inst_w);
        return pc_w + inst_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_inst_queue_ram.sv
`default_nettype none
// ============================================================================
// Module   : id_inst_queue_ram
// Brief    : DEPTH x WIDTH register array, one write port, async read port.
// Revision : 1.0
// ============================================================================
module id_inst_queue_ram
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH = INSTQ_DEPTH,
    parameter int WIDTH = entry_w(INSTQ_PC_W, INSTQ_INST_W)
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are qualified by the queue count, so no reset is needed
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/id_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : id_inst_queue
// Brief    : IF->ID instruction queue with response capture, bypass and
//            branch flush with optional delay-slot preservation.
// Revision : 1.0
// ============================================================================
module id_inst_queue
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH      = INSTQ_DEPTH,
    parameter int PC_W       = INSTQ_PC_W,
    parameter int INST_W     = INSTQ_INST_W,
    parameter int DELAY_SLOT = 1,
    parameter int BYPASS     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_if_valid,
    input  logic [PC_W-1:0]          i_if_pc,
    output logic                     o_if_ready,
    input  logic [INST_W-1:0]        i_inst_sram_rdata,
    input  logic                     i_id_stall,
    input  logic                     i_flush,
    output logic                     o_id_valid,
    output logic [PC_W-1:0]          o_id_pc,
    output logic [INST_W-1:0]        o_id_inst,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam int              c_CW      = c_AW + 1;
    localparam int              c_EW      = entry_w(PC_W, INST_W);
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
    localparam logic            c_BYPASS  = (BYPASS != 0);
    localparam logic            c_DSLOT   = (DELAY_SLOT != 0);

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_pend;
    logic             r_pend_kill;
    logic             r_keep_next;
    logic [PC_W-1:0]  r_pend_pc;

    logic [c_AW-1:0]  w_wr_ptr_nxt;
    logic [c_AW-1:0]  w_rd_ptr_nxt;
    logic [c_CW-1:0]  w_count_nxt;
    logic [c_CW-1:0]  w_occ;
    logic             w_not_empty;
    logic             w_req_fire;
    logic             w_rsp_raw;
    logic             w_rsp;
    logic             w_drop_rsp;
    logic             w_bypass;
    logic             w_pop;
    logic             w_pop_q;
    logic             w_push;
    logic [c_EW-1:0]  w_rsp_entry;
    logic [c_EW-1:0]  w_head;
    flush_act_e       w_action;

    assign w_not_empty = (r_count != '0);
    assign w_occ       = r_count + {{(c_CW-1){1'b0}}, r_pend};
    assign o_if_ready  = ~i_flush & (w_occ < c_DEPTH);
    assign w_req_fire  = i_if_valid & o_if_ready;

    // A kept-next response overrides a stale kill from an earlier flush
    assign w_rsp_raw   = r_pend & (~r_pend_kill | r_keep_next);
    assign w_rsp_entry = {r_pend_pc, i_inst_sram_rdata};

    always_comb begin
        w_action = FL_NONE;
        if (i_flush) begin
            if (!c_DSLOT) begin
                w_action = FL_DROP_ALL;
            end else if (w_not_empty) begin
                w_action = FL_KEEP_HEAD;
            end else if (w_rsp_raw) begin
                w_action = FL_KEEP_RSP;
            end else begin
                w_action = FL_ARM_KEEP;
            end
        end
    end

    assign w_drop_rsp = (w_action == FL_DROP_ALL) | (w_action == FL_KEEP_HEAD);
    assign w_rsp      = w_rsp_raw & ~w_drop_rsp;
    assign w_bypass   = c_BYPASS & ~w_not_empty & w_rsp;

    always_comb begin
        o_id_valid = 1'b0;
        o_id_pc    = '0;
        o_id_inst  = '0;
        if (w_not_empty) begin
            o_id_valid           = 1'b1;
            {o_id_pc, o_id_inst} = w_head;
        end else if (w_bypass) begin
            o_id_valid           = 1'b1;
            {o_id_pc, o_id_inst} = w_rsp_entry;
        end
    end

    assign w_pop   = o_id_valid & (i_id_stall == c_NOSTOP);
    assign w_pop_q = w_pop & w_not_empty;
    // A bypassed response consumed by ID this cycle never touches storage
    assign w_push  = w_rsp & ~(w_bypass & w_pop);

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        case (w_action)
            FL_DROP_ALL: begin
                w_wr_ptr_nxt = r_rd_ptr;
                w_count_nxt  = '0;
            end
            FL_KEEP_HEAD: begin
                // The head is the delay slot; a pop this cycle consumes it
                w_wr_ptr_nxt = r_rd_ptr + c_PTR_ONE;
                if (w_pop) begin
                    w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
                    w_count_nxt  = '0;
                end else begin
                    w_count_nxt  = c_CNT_ONE;
                end
            end
            default: begin
                if (w_push) begin
                    w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop_q) begin
                    w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
                end
                case ({w_push, w_pop_q})
                    2'b10:   w_count_nxt = r_count + c_CNT_ONE;
                    2'b01:   w_count_nxt = r_count - c_CNT_ONE;
                    default: w_count_nxt = r_count;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pend      <= 1'b0;
            r_pend_kill <= 1'b0;
            r_keep_next <= 1'b0;
            r_pend_pc   <= '0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_pend      <= w_req_fire;
            r_pend_kill <= r_pend & w_drop_rsp;
            if (w_req_fire) begin
                r_pend_pc <= i_if_pc;
            end
            if (w_action == FL_ARM_KEEP) begin
                r_keep_next <= 1'b1;
            end else if (w_rsp_raw) begin
                r_keep_next <= 1'b0;
            end
        end
    end

    id_inst_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_EW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_rsp_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_id_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_inst_queue
// Brief    : Self-checking bench: queue-based reference model plus directed
//            scenarios and randomized traffic.
// Revision : 1.0
// ============================================================================
module tb_id_inst_queue;
    import id_inst_queue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_if_valid = 1'b0;
    logic [PC_W-1:0]   i_if_pc = '0;
    logic              o_if_ready;
    logic [INST_W-1:0] sram_rdata = '0;
    logic              i_id_stall = 1'b0;
    logic              i_flush = 1'b0;
    logic              o_id_valid;
    logic [PC_W-1:0]   o_id_pc;
    logic [INST_W-1:0] o_id_inst;
    logic [2:0]        o_count;

    logic [PC_W-1:0]   pc_nxt = 32'h0000_8000;
    int                n_chk  = 0;
    int                n_pass = 0;
    int                n_fail = 0;
    bit                chk_en = 1'b0;

    always #5 clk = ~clk;

    id_inst_queue #(
        .DEPTH      (DEPTH),
        .PC_W       (PC_W),
        .INST_W     (INST_W),
        .DELAY_SLOT (1),
        .BYPASS     (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_if_valid        (i_if_valid),
        .i_if_pc           (i_if_pc),
        .o_if_ready        (o_if_ready),
        .i_inst_sram_rdata (sram_rdata),
        .i_id_stall        (i_id_stall),
        .i_flush           (i_flush),
        .o_id_valid        (o_id_valid),
        .o_id_pc           (o_id_pc),
        .o_id_inst         (o_id_inst),
        .o_count           (o_count)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0] ^ 16'h5A5A, ~pc[15:0]};
    endfunction

    // Instruction SRAM: data for an accepted request appears next cycle
    always @(posedge clk) begin
        if (i_if_valid && o_if_ready) begin
            sram_rdata <= inst_of(i_if_pc);
            pc_nxt     <= i_if_pc + 32'd4;
        end else begin
            sram_rdata <= $urandom;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_pc = '0;

    // Reference model and per-cycle comparison
    always @(negedge clk) begin : p_cmp
        int          n;
        bit          rsp, byp, pop, e_valid, e_ready;
        ent_t        rsp_e;
        logic [31:0] e_pc, e_inst;
        if (!rst_n) begin
            mq.delete();
            m_pend = 1'b0;
        end else if (chk_en) begin
            n        = mq.size();
            e_ready  = !i_flush && ((n + int'(m_pend)) < DEPTH);
            rsp      = m_pend;
            rsp_e.pc   = m_pend_pc;
            rsp_e.inst = inst_of(m_pend_pc);
            if (i_flush && n != 0) rsp = 1'b0;
            e_valid = 1'b0; e_pc = '0; e_inst = '0; byp = 1'b0;
            if (n != 0) begin
                e_valid = 1'b1; e_pc = mq[0].pc; e_inst = mq[0].inst;
            end else if (rsp) begin
                e_valid = 1'b1; e_pc = rsp_e.pc; e_inst = rsp_e.inst; byp = 1'b1;
            end
            check("id_valid", 64'(o_id_valid), 64'(e_valid));
            check("id_pc",    64'(o_id_pc),    64'(e_pc));
            check("id_inst",  64'(o_id_inst),  64'(e_inst));
            check("count",    64'(o_count),    64'(n));
            check("if_ready", 64'(o_if_ready), 64'(e_ready));
            pop = e_valid && !i_id_stall;
            if (pop && n != 0) void'(mq.pop_front());
            if (rsp && !(byp && pop)) mq.push_back(rsp_e);
            if (i_flush && n != 0) begin
                if (pop) mq.delete();
                else while (mq.size() > 1) void'(mq.pop_back());
            end
            m_pend = i_if_valid && e_ready;
            if (m_pend) m_pend_pc = i_if_pc;
        end
    end

    task automatic drive(input bit v, input logic [31:0] pc, input bit st, input bit fl);
        @(posedge clk);
        #1;
        i_if_valid = v;
        i_if_pc    = pc;
        i_id_stall = st;
        i_flush    = fl;
    endtask

    task automatic at_mid;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_valid", 64'(o_id_valid), 64'd0);
        check("rst_count", 64'(o_count),    64'd0);
        check("rst_pc",    64'(o_id_pc),    64'd0);
        check("rst_inst",  64'(o_id_inst),  64'd0);
        check("rst_ready", 64'(o_if_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Straight-line fetch with bypass
        drive(1, 32'h1000, 0, 0); at_mid;
        check("sl_c0_valid", 64'(o_id_valid), 64'd0);
        drive(1, 32'h1004, 0, 0); at_mid;
        check("sl_c1_pc",    64'(o_id_pc),   64'h1000);
        check("sl_c1_inst",  64'(o_id_inst), 64'h4A5A_EFFF);
        check("sl_c1_count", 64'(o_count),   64'd0);
        drive(1, 32'h1008, 0, 0); at_mid;
        check("sl_c2_pc",    64'(o_id_pc),   64'h1004);
        drive(0, 32'h0, 0, 0); at_mid;
        check("sl_c3_pc",    64'(o_id_pc),   64'h1008);
        check("sl_c3_count", 64'(o_count),   64'd0);

        // Long stall fills the queue, then drains in order
        for (int k = 0; k < 6; k++) begin
            drive(1, (k < 4) ? 32'h1000 + 32'(4 * k) : 32'h1010, 1, 0);
        end
        at_mid;
        check("ls_count", 64'(o_count),    64'd4);
        check("ls_ready", 64'(o_if_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 32'h0, 0, 0); at_mid;
            check("ls_drain_pc", 64'(o_id_pc), 64'(32'h1000 + 32'(4 * k)));
        end
        drive(0, 32'h0, 0, 0); at_mid;
        check("ls_empty", 64'(o_id_valid), 64'd0);

        // Flush keeps only the delay slot and discards the pending response
        drive(1, 32'h2004, 1, 0);
        drive(1, 32'h2008, 1, 0);
        drive(1, 32'h200C, 1, 0);
        drive(1, 32'h2010, 1, 0);
        drive(0, 32'h0, 1, 1); at_mid;
        check("fl_pre_count", 64'(o_count),    64'd3);
        check("fl_pre_pc",    64'(o_id_pc),    64'h2004);
        check("fl_ready",     64'(o_if_ready), 64'd0);
        drive(1, 32'h3000, 0, 0); at_mid;
        check("fl_ds_count",  64'(o_count),    64'd1);
        check("fl_ds_pc",     64'(o_id_pc),    64'h2004);
        drive(0, 32'h0, 0, 0); at_mid;
        check("fl_tgt_pc",    64'(o_id_pc),    64'h3000);
        check("fl_tgt_count", 64'(o_count),    64'd0);

        // Flush on an empty queue keeps the next arriving response
        drive(0, 32'h0, 0, 1); at_mid;
        check("fe_valid", 64'(o_id_valid), 64'd0);
        drive(1, 32'h2004, 1, 0); at_mid;
        drive(0, 32'h0, 1, 0); at_mid;
        check("fe_ds_valid", 64'(o_id_valid), 64'd1);
        check("fe_ds_pc",    64'(o_id_pc),    64'h2004);
        drive(1, 32'h3000, 0, 0); at_mid;
        check("fe_ds_count", 64'(o_count),    64'd1);
        drive(0, 32'h0, 0, 0); at_mid;
        check("fe_tgt_pc",   64'(o_id_pc),    64'h3000);

        // Asynchronous reset mid-stall
        drive(1, 32'h4000, 1, 0);
        drive(1, 32'h4004, 1, 0);
        drive(1, 32'h4008, 1, 0);
        drive(0, 32'h0, 1, 0);
        @(posedge clk);
        #2;
        check("ar_pre_count", 64'(o_count), 64'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(o_id_valid), 64'd0);
        check("ar_count", 64'(o_count),    64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 32'h5000, 0, 0); at_mid;
        check("ar_post_valid", 64'(o_id_valid), 64'd0);
        drive(0, 32'h0, 0, 0); at_mid;
        check("ar_post_pc",    64'(o_id_pc),    64'h5000);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            i_if_valid = ($urandom_range(3) != 0);
            i_if_pc    = pc_nxt;
            i_id_stall = (k % 200 < 20) ? 1'b1 : ($urandom_range(2) == 0);
            i_flush    = ($urandom_range(9) == 0);
        end
        drive(0, 32'h0, 0, 0);
        repeat (2) @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
